// File: rtl/vedic_mul_arbiter_pkg.sv
// Shared constants, result type and round-robin pick helper for the
// Vedic multiplier arbiter.
package vmul_arb_pkg;

    localparam int OUT_DEPTH = 4;
    localparam int MUL_LAT   = 2;
    localparam int MAX_REQ   = 8;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] p;
    } mul_rsp_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First valid index at or after ptr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int unsigned        nreq);
        rr_pick_t    pick;
        int unsigned idx;
        pick = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % nreq;
            if (k < nreq && !pick.found && valid[idx]) begin
                pick.found = 1'b1;
                pick.idx   = 3'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/vedic_mul_arbiter_if.sv
// Requester-side and response-side handshake bundle of vedic_mul_arbiter.
interface vedic_mul_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0][7:0] req_a;
    logic [NREQ-1:0][7:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/vedic_mul8_pipe.sv
// Two-stage unsigned 8x8 Urdhva-Tiryakbhyam multiplier: stage 1 forms four
// 4x4 vertical-crosswise partial products, stage 2 aligns and sums them.
module vedic_mul8_pipe
    import vmul_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_id,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    output logic [7:0]  out_id,
    output logic [15:0] p
);

    // Column k collects every bit pair a[i]&b[j] with i+j == k.
    function automatic logic [7:0] ut_mul4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] acc;
        logic [2:0] col;
        int         j;
        acc = '0;
        for (int k = 0; k < 7; k++) begin
            col = '0;
            for (int i = 0; i < 4; i++) begin
                j = k - i;
                if (j >= 0 && j < 4) col = col + 3'(x[i] & y[j[1:0]]);
            end
            acc = acc + (8'(col) << k);
        end
        return acc;
    endfunction

    logic       s1_valid;
    logic [7:0] s1_id;
    logic [7:0] pp_ll, pp_hl, pp_lh, pp_hh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking so both stages shift on the same edge.
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        s1_id  <= in_id;
        pp_ll  <= ut_mul4(a[3:0], b[3:0]);
        pp_hl  <= ut_mul4(a[7:4], b[3:0]);
        pp_lh  <= ut_mul4(a[3:0], b[7:4]);
        pp_hh  <= ut_mul4(a[7:4], b[7:4]);
        out_id <= s1_id;
        p      <= 16'(pp_ll) + ((16'(pp_hl) + 16'(pp_lh)) << 4) + (16'(pp_hh) << 8);
    end

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Round-robin, credit-guarded sharing of one vedic_mul8_pipe among NREQ requesters.
// Define VMUL_ARB_STATS_EN to add the op_count / stall_count outputs.
module vedic_mul_arbiter
    import vmul_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    vedic_mul_arbiter_if.slave  bus
`ifdef VMUL_ARB_STATS_EN
    ,
    output logic [31:0]         op_count,
    output logic [31:0]         stall_count
`endif
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;

    logic [IDW-1:0] ptr;
    logic           stage1_valid;
    logic [1:0]     inflight;
    logic           credit;
    logic           accept;
    rr_pick_t       pick;

    logic           mul_valid;
    logic [7:0]     mul_id;
    logic [15:0]    mul_p;

    mul_rsp_t       mem [OUT_DEPTH];
    mul_rsp_t       head;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           push, pop, full, not_empty;

    // Credit counts every issued op not yet popped, so a FIFO slot always waits for it.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        bus.req_ready = '0;
        inflight      = {1'b0, stage1_valid} + {1'b0, mul_valid};
        credit        = (int'(count) + int'(inflight)) < OUT_DEPTH;
        pick          = rr_pick(MAX_REQ'(bus.req_valid), 3'(ptr), NREQ);
        accept        = rst_n && credit && pick.found;
        if (accept) bus.req_ready[IDW'(pick.idx)] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            stage1_valid <= 1'b0;
        end else begin
            stage1_valid <= accept;
            if (accept)
                ptr <= (int'(pick.idx) == NREQ - 1) ? '0 : IDW'(pick.idx + 3'd1);
        end
    end

    vedic_mul8_pipe u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_id     (8'(pick.idx)),
        .a         (bus.req_a[IDW'(pick.idx)]),
        .b         (bus.req_b[IDW'(pick.idx)]),
        .out_valid (mul_valid),
        .out_id    (mul_id),
        .p         (mul_p)
    );

    assign push      = mul_valid;
    assign full      = (count == CW'(OUT_DEPTH));
    assign not_empty = (count != '0);
    assign pop       = not_empty && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the empty flag masks stale entries at the outputs.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{id: mul_id, p: mul_p};
    end

    always_comb begin
        head          = mem[rd_ptr];
        bus.rsp_valid = not_empty;
        bus.rsp_id    = not_empty ? IDW'(head.id) : '0;
        bus.rsp_p     = not_empty ? head.p : '0;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

`ifdef VMUL_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count    <= '0;
            stall_count <= '0;
        end else begin
            if (accept) op_count <= op_count + 32'd1;
            if ((|bus.req_valid) && !credit) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Randomized scoreboard bench for vedic_mul_arbiter: a negedge monitor predicts
// round-robin grants from a credit/outstanding model and checks responses in order.
module tb_vedic_mul_arbiter;
    import vmul_arb_pkg::*;

    localparam int NREQ = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vedic_mul_arbiter_if #(.NREQ(NREQ)) bus ();

`ifdef VMUL_ARB_STATS_EN
    logic [31:0] op_count, stall_count;
`endif

    vedic_mul_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef VMUL_ARB_STATS_EN
        ,
        .op_count    (op_count),
        .stall_count (stall_count)
`endif
    );

    typedef struct {
        int id;
        int p;
    } exp_t;

    exp_t            exp_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              outstanding = 0;
    int              mptr = 0;
    int              n_acc = 0;
    int              n_pop = 0;
    int              stat_ops = 0;
    int              stat_stall = 0;
    logic [NREQ-1:0] acc_mask = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(7))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    // Reference: results are owed in acceptance order; a grant is allowed while
    // fewer than OUT_DEPTH ops are accepted-but-not-popped.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] acc;
        int              idx;
        if (!rst_n) begin
            exp_q.delete();
            outstanding = 0;
            mptr        = 0;
            acc_mask    = '0;
            stat_ops    = 0;
            stat_stall  = 0;
        end else begin
            exp_ready = '0;
            if (outstanding < OUT_DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (mptr + k) % NREQ;
                    if (bus.req_valid[idx] && exp_ready == '0) exp_ready[idx] = 1'b1;
                end
            end else if (|bus.req_valid) begin
                stat_stall++;
            end
            check("req_ready", bus.req_ready, exp_ready);
            acc = bus.req_valid & bus.req_ready;

            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    check("rsp_id", bus.rsp_id, exp_q[0].id);
                    check("rsp_p", bus.rsp_p, exp_q[0].p);
                    if (bus.rsp_ready) begin
                        void'(exp_q.pop_front());
                        outstanding--;
                        n_pop++;
                    end
                end
            end

            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    exp_q.push_back('{i, int'(bus.req_a[i]) * int'(bus.req_b[i])});
                    mptr = (i + 1) % NREQ;
                    outstanding++;
                    n_acc++;
                    stat_ops++;
                end
            end
            acc_mask = acc;
        end
    end

    // One cycle of stimulus: retire accepted requests, refill with probability p_valid.
    task automatic drive_cycle(input int p_valid, input int p_ready);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && acc_mask[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i] && $urandom_range(99) < p_valid) begin
                bus.req_valid[i] = 1'b1;
                bus.req_a[i]     = rand_byte();
                bus.req_b[i]     = rand_byte();
            end
        end
        bus.rsp_ready = ($urandom_range(99) < p_ready);
    endtask

    task automatic drain();
        int t = 0;
        while ((outstanding != 0 || bus.req_valid != '0) && t < 200) begin
            drive_cycle(0, 100);
            t++;
        end
        check("drain_outstanding", outstanding, 0);
    endtask

    task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp_p);
        int t;
        int lat;
        drain();
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b1;
        bus.req_a[id]     = a;
        bus.req_b[id]     = b;
        bus.rsp_ready     = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!acc_mask[id] && t < 20);
        check("single_accept", acc_mask[id], 1);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            #1;
        end while (!bus.rsp_valid && lat < 20);
        check("single_latency", lat, MUL_LAT);
        check("single_rsp_id", bus.rsp_id, id);
        check("single_rsp_p", bus.rsp_p, exp_p);
    endtask

    initial begin
        int n0, n1, p0, t;

        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i] = rand_byte();
            bus.req_b[i] = rand_byte();
        end
        #1;
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_id", bus.rsp_id, 0);
        check("reset_rsp_p", bus.rsp_p, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Saturated requesters with a free consumer: one accept every cycle.
        repeat (8) drive_cycle(100, 100);
        n0 = n_acc;
        repeat (16) drive_cycle(100, 100);
        check("throughput", n_acc - n0, 16);

        single_op(2, 8'h0F, 8'h11, 16'h00FF);
        single_op(1, 8'hFF, 8'hFF, 16'hFE01);
        single_op(3, 8'h00, 8'hAB, 16'h0000);
        single_op(0, 8'h80, 8'h02, 16'h0100);

        // Consumer stalled: credit admits exactly OUT_DEPTH ops.
        drain();
        n0 = n_acc;
        repeat (12) drive_cycle(100, 0);
        check("bp_accepts", n_acc - n0, OUT_DEPTH);
        check("bp_req_ready", bus.req_ready, 0);
        p0 = n_pop;
        n1 = n_acc;
        repeat (12) drive_cycle(100, 100);
        check("bp_drained", (n_pop - p0) >= OUT_DEPTH, 1);
        check("bp_resume", n_acc > n1, 1);

        // One pop timed to coincide with a push at count 3 frees exactly one slot.
        drain();
        n0 = n_acc;
        t  = 0;
        while (n_acc - n0 < OUT_DEPTH && t < 20) begin
            drive_cycle(100, 0);
            t++;
        end
        drive_cycle(100, 100);
        drive_cycle(100, 0);
        repeat (6) drive_cycle(100, 0);
        check("push_pop_at_3", n_acc - n0, OUT_DEPTH + 1);
        repeat (10) drive_cycle(100, 100);

        // Random traffic with random backpressure.
        n0 = n_acc;
        t  = 0;
        while (n_acc - n0 < 1000 && t < 6000) begin
            drive_cycle(60, 70);
            t++;
        end
        check("random_ops", (n_acc - n0) >= 1000, 1);

        // Reset with two ops in flight and two buffered.
        drain();
        n0 = n_acc;
        t  = 0;
        while (n_acc - n0 < OUT_DEPTH && t < 20) begin
            drive_cycle(100, 0);
            t++;
        end
        rst_n         = 1'b0;
        bus.req_valid = '1;
        #1;
        check("midrst_req_ready", bus.req_ready, 0);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_rsp_id", bus.rsp_id, 0);
        check("midrst_rsp_p", bus.rsp_p, 0);
`ifdef VMUL_ARB_STATS_EN
        check("midrst_op_count", op_count, 0);
        check("midrst_stall_count", stall_count, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b1;
        repeat (6) begin
            drive_cycle(0, 100);
            check("post_reset_rsp_valid", bus.rsp_valid, 0);
        end

        repeat (200) drive_cycle(50, 50);
        drain();
        check("queue_empty", exp_q.size(), 0);
`ifdef VMUL_ARB_STATS_EN
        check("op_count", op_count, stat_ops);
        check("stall_count", stall_count, stat_stall);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
